// File: rtl/pipeline_run_ctrl.sv
// rtl/pipeline_run_ctrl.sv - run/halt/single-step sequencer driving the pipeline Halt input
// Optional PC breakpoint is compiled in when RUNCTL_BREAKPOINT_EN is defined.
module pipeline_run_ctrl #(
    parameter int PC_W         = 9,
    parameter int DRAIN_CYCLES = 4,
    parameter int CNT_W        = 32,
    parameter int RESET_HALTED = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             halt_req,
    input  logic             resume_req,
    input  logic             step_req,
    input  logic [PC_W-1:0]  pc,
    input  logic [PC_W-1:0]  bp_addr,
    input  logic             bp_valid,
    output logic             halt,
    output logic             halted,
    output logic             step_done,
    output logic [1:0]       halt_cause,
    output logic [CNT_W-1:0] run_cycles
);

    typedef enum logic [1:0] {
        S_RUN    = 2'd0,
        S_DRAIN  = 2'd1,
        S_HALTED = 2'd2,
        S_STEP   = 2'd3
    } state_e;

    localparam state_e     RESET_STATE = (RESET_HALTED != 0) ? S_HALTED : S_RUN;
    localparam logic [3:0] DRAIN_LOAD  = 4'(DRAIN_CYCLES - 1);

    localparam logic [1:0] CAUSE_NONE = 2'b00;
    localparam logic [1:0] CAUSE_HOST = 2'b01;
    localparam logic [1:0] CAUSE_BP   = 2'b10;
    localparam logic [1:0] CAUSE_STEP = 2'b11;

    state_e           state_q, state_d;
    logic [3:0]       drain_cnt_q, drain_cnt_d;
    logic [1:0]       cause_q, cause_d;
    logic             step_done_q, step_done_d;
    logic [CNT_W-1:0] run_cycles_q, run_cycles_d;
    logic             bp_hit;

`ifdef RUNCTL_BREAKPOINT_EN
    logic bp_armed_q, bp_armed_d;

    // Disarm on leaving HALTED so resuming at the breakpoint PC does not re-trigger.
    always_comb begin
        bp_armed_d = bp_armed_q;
        if (state_q == S_HALTED && (resume_req || step_req)) begin
            bp_armed_d = 1'b0;
        end else if (pc != bp_addr) begin
            bp_armed_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bp_armed_q <= 1'b1;
        end else begin
            bp_armed_q <= bp_armed_d;
        end
    end

    assign bp_hit = bp_valid && (pc == bp_addr) && bp_armed_q;
`else
    logic unused_bp;
    assign unused_bp = ^{pc, bp_addr, bp_valid};
    assign bp_hit    = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        drain_cnt_d  = drain_cnt_q;
        cause_d      = cause_q;
        step_done_d  = 1'b0;
        run_cycles_d = halt ? run_cycles_q : run_cycles_q + CNT_W'(1);

        case (state_q)
            S_RUN: begin
                if (halt_req) begin
                    state_d     = S_DRAIN;
                    drain_cnt_d = DRAIN_LOAD;
                    cause_d     = CAUSE_HOST;
                end else if (bp_hit) begin
                    state_d     = S_DRAIN;
                    drain_cnt_d = DRAIN_LOAD;
                    cause_d     = CAUSE_BP;
                end
            end
            S_DRAIN: begin
                if (drain_cnt_q == 4'd0) begin
                    state_d     = S_HALTED;
                    step_done_d = (cause_q == CAUSE_STEP);
                end else begin
                    drain_cnt_d = drain_cnt_q - 4'd1;
                end
            end
            S_HALTED: begin
                if (resume_req) begin
                    state_d = S_RUN;
                    cause_d = CAUSE_NONE;
                end else if (step_req) begin
                    state_d = S_STEP;
                    cause_d = CAUSE_STEP;
                end
            end
            S_STEP: begin
                state_d     = S_DRAIN;
                drain_cnt_d = DRAIN_LOAD;
            end
            default: begin
                state_d = RESET_STATE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= RESET_STATE;
            drain_cnt_q  <= 4'd0;
            cause_q      <= CAUSE_NONE;
            step_done_q  <= 1'b0;
            run_cycles_q <= '0;
        end else begin
            state_q      <= state_d;
            drain_cnt_q  <= drain_cnt_d;
            cause_q      <= cause_d;
            step_done_q  <= step_done_d;
            run_cycles_q <= run_cycles_d;
        end
    end

    assign halt       = (state_q == S_DRAIN) || (state_q == S_HALTED);
    assign halted     = (state_q == S_HALTED);
    assign step_done  = step_done_q;
    assign halt_cause = cause_q;
    assign run_cycles = run_cycles_q;

endmodule
